// File: rtl/c1_layer_sequencer_pkg.sv
// Shared constants and state encoding for the LeNet C1 stage
// (sequencer, register controller and PE array).
package c1_pkg;

   localparam int IMG_W     = 32;
   localparam int K         = 5;
   localparam int OUT_W     = IMG_W - K + 1;
   localparam int POOL_BLKS = (OUT_W / 2) * (OUT_W / 2);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      DRAIN     = 3'd2,
      WAIT_POOL = 3'd3,
      DONE      = 3'd4
   } seq_state_t;

endpackage

// File: rtl/c1_layer_sequencer_if.sv
// Control/status bundle between frame control, the C1 PEs and the pooling controller.
// C1_SEQ_PERF_EN adds the frame_cycles / hold_cycles performance counters.
interface c1_layer_sequencer_if;

   logic       start;
   logic       abort;
   logic       hold;
   logic       pool_valid;
   logic       win_valid;
   logic [4:0] win_row;
   logic [4:0] win_col;
   logic       conv_valid;
   logic [7:0] pool_cnt;
   logic       busy;
   logic       done;
   logic       pool_err;
`ifdef C1_SEQ_PERF_EN
   logic [15:0] frame_cycles;
   logic [15:0] hold_cycles;

   modport master (
      output start, abort, hold, pool_valid,
      input  win_valid, win_row, win_col, conv_valid, pool_cnt, busy, done, pool_err,
      input  frame_cycles, hold_cycles
   );

   modport slave (
      input  start, abort, hold, pool_valid,
      output win_valid, win_row, win_col, conv_valid, pool_cnt, busy, done, pool_err,
      output frame_cycles, hold_cycles
   );
`else
   modport master (
      output start, abort, hold, pool_valid,
      input  win_valid, win_row, win_col, conv_valid, pool_cnt, busy, done, pool_err
   );

   modport slave (
      input  start, abort, hold, pool_valid,
      output win_valid, win_row, win_col, conv_valid, pool_cnt, busy, done, pool_err
   );
`endif

endinterface

// File: rtl/c1_layer_sequencer_valid_delay.sv
// LAT-deep valid shift register aligning win_valid with the PE result (conv_valid).
module c1_valid_delay #(
   parameter int LAT = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_flush,
   input  logic i_in,
   output logic o_out
);

   logic [LAT-1:0] r_pipe;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pipe <= '0;
      end else if (i_flush) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= i_in;
         for (int i = 1; i < LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_out = r_pipe[LAT-1];

endmodule

// File: rtl/c1_layer_sequencer.sv
// C1 frame sequencer: scans 28x28 window positions, aligns conv_valid, counts pool blocks.
// Optional C1_SEQ_PERF_EN adds frame_cycles / hold_cycles counters.
module c1_layer_sequencer
   import c1_pkg::*;
#(
   parameter int PE_LAT = 3
) (
   input logic                 clk,
   input logic                 reset_n,
   c1_layer_sequencer_if.slave bus
);

   seq_state_t r_state;
   seq_state_t w_next;
   logic [4:0] r_row;
   logic [4:0] r_col;
   logic [3:0] r_drain;
   logic [7:0] r_pool_cnt;
   logic       r_pool_err;
   logic       w_issue;
   logic       w_last;
   logic       w_pool_full;
   logic       w_busy;
   logic       w_done;
   logic       w_conv;

   assign w_last      = (r_row == 5'(OUT_W - 1)) && (r_col == 5'(OUT_W - 1));
   assign w_pool_full = (r_pool_cnt == 8'(POOL_BLKS));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // abort dominates every transition, including start in IDLE
   always_comb begin
      w_next  = r_state;
      w_issue = 1'b0;
      w_busy  = (r_state != IDLE);
      w_done  = (r_state == DONE);
      if (r_state == ISSUE && !bus.hold && !bus.abort) begin
         w_issue = 1'b1;
      end
      if (bus.abort) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE:      if (bus.start) w_next = ISSUE;
            ISSUE:     if (w_issue && w_last) w_next = DRAIN;
            DRAIN:     if (r_drain == 4'(PE_LAT - 1)) w_next = WAIT_POOL;
            WAIT_POOL: if (w_pool_full) w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_row   <= '0;
         r_col   <= '0;
         r_drain <= '0;
      end else if (bus.abort) begin
         r_row   <= '0;
         r_col   <= '0;
         r_drain <= '0;
      end else begin
         if (w_issue) begin
            if (r_col == 5'(OUT_W - 1)) begin
               r_col <= '0;
               r_row <= w_last ? 5'd0 : r_row + 5'd1;
            end else begin
               r_col <= r_col + 5'd1;
            end
         end
         r_drain <= (r_state == DRAIN) ? r_drain + 4'd1 : 4'd0;
      end
   end

   // pool blocks may return mid-frame, so counting runs in every busy state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pool_cnt <= '0;
         r_pool_err <= 1'b0;
      end else begin
         if (bus.pool_valid && (r_state == IDLE || w_pool_full)) begin
            r_pool_err <= 1'b1;
         end
         if (bus.abort || (r_state == IDLE && bus.start)) begin
            r_pool_cnt <= '0;
         end else if (w_busy && bus.pool_valid && !w_pool_full) begin
            r_pool_cnt <= r_pool_cnt + 8'd1;
         end
      end
   end

   c1_valid_delay #(
      .LAT (PE_LAT)
   ) u_valid_delay (
      .clk     (clk),
      .reset_n (reset_n),
      .i_flush (bus.abort),
      .i_in    (w_issue),
      .o_out   (w_conv)
   );

   assign bus.win_valid  = w_issue;
   assign bus.win_row    = r_row;
   assign bus.win_col    = r_col;
   assign bus.conv_valid = w_conv;
   assign bus.pool_cnt   = r_pool_cnt;
   assign bus.busy       = w_busy;
   assign bus.done       = w_done;
   assign bus.pool_err   = r_pool_err;

`ifdef C1_SEQ_PERF_EN
   logic [15:0] r_frame_cycles;
   logic [15:0] r_hold_cycles;

   // values persist through IDLE until the next accepted start
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_cycles <= '0;
         r_hold_cycles  <= '0;
      end else if (r_state == IDLE && bus.start && !bus.abort) begin
         r_frame_cycles <= '0;
         r_hold_cycles  <= '0;
      end else begin
         if (w_busy && r_frame_cycles != 16'hFFFF) begin
            r_frame_cycles <= r_frame_cycles + 16'd1;
         end
         if (r_state == ISSUE && bus.hold && !bus.abort && r_hold_cycles != 16'hFFFF) begin
            r_hold_cycles <= r_hold_cycles + 16'd1;
         end
      end
   end

   assign bus.frame_cycles = r_frame_cycles;
   assign bus.hold_cycles  = r_hold_cycles;
`endif

endmodule

// File: tb/tb_c1_layer_sequencer.sv
// Directed bench for c1_layer_sequencer: vector table plus multi-cycle frame, abort and reset sequences.
module tb_c1_layer_sequencer;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   c1_layer_sequencer_if bus ();

   c1_layer_sequencer #(
      .PE_LAT (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      int s, a, h, p;
      int wv, row, col, cv, busy, done, err, cnt;
   } vec_t;

   vec_t vecs[19];
   int   vecCount = 0;
   int   missCount = 0;
   logic hist[0:3999];

   function automatic vec_t mkVec(int s, int a, int h, int p, int wv, int row, int col,
                                  int cv, int busy, int done, int err, int cnt);
      vec_t v;
      v.s = s; v.a = a; v.h = h; v.p = p;
      v.wv = wv; v.row = row; v.col = col; v.cv = cv;
      v.busy = busy; v.done = done; v.err = err; v.cnt = cnt;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      vecCount++;
      if (act != exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic h, input logic p);
      @(negedge clk);
      bus.start      = s;
      bus.abort      = a;
      bus.hold       = h;
      bus.pool_valid = p;
      #1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int   expRow, expCol, wins, holdsUsed, convSeen, doneCnt, doneCyc;
      int   firstWin, lastWin, lastRow, lastCol, foundCyc, sawDone;
      logic h, s, ew, poolPend;

      bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0; bus.pool_valid = 1'b0;

      // start+abort together, hold gap, start while busy, abort, pool_valid in IDLE
      vecs[0]  = mkVec(0,0,0,0, 0,0,0,0, 0,0,0,0);
      vecs[1]  = mkVec(1,1,0,0, 0,0,0,0, 0,0,0,0);
      vecs[2]  = mkVec(0,0,0,0, 0,0,0,0, 0,0,0,0);
      vecs[3]  = mkVec(1,0,0,0, 0,0,0,0, 0,0,0,0);
      vecs[4]  = mkVec(0,0,0,0, 1,0,0,0, 1,0,0,0);
      vecs[5]  = mkVec(0,0,0,0, 1,0,1,0, 1,0,0,0);
      vecs[6]  = mkVec(0,0,1,0, 0,0,2,0, 1,0,0,0);
      vecs[7]  = mkVec(0,0,0,0, 1,0,2,1, 1,0,0,0);
      vecs[8]  = mkVec(0,0,0,0, 1,0,3,1, 1,0,0,0);
      vecs[9]  = mkVec(1,0,0,0, 1,0,4,0, 1,0,0,0);
      vecs[10] = mkVec(0,0,0,1, 1,0,5,1, 1,0,0,0);
      vecs[11] = mkVec(0,1,0,0, 0,0,6,1, 1,0,0,1);
      vecs[12] = mkVec(0,0,0,0, 0,0,0,0, 0,0,0,0);
      vecs[13] = mkVec(0,0,0,1, 0,0,0,0, 0,0,0,0);
      vecs[14] = mkVec(0,0,0,0, 0,0,0,0, 0,0,1,0);
      vecs[15] = mkVec(1,0,0,0, 0,0,0,0, 0,0,1,0);
      vecs[16] = mkVec(0,0,0,0, 1,0,0,0, 1,0,1,0);
      vecs[17] = mkVec(0,1,0,0, 0,0,1,0, 1,0,1,0);
      vecs[18] = mkVec(0,0,0,0, 0,0,0,0, 0,0,1,0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         applyStimulus(vecs[i].s[0], vecs[i].a[0], vecs[i].h[0], vecs[i].p[0]);
         checkOutput($sformatf("vec%0d win_valid", i),  int'(bus.win_valid),  vecs[i].wv);
         checkOutput($sformatf("vec%0d win_row", i),    int'(bus.win_row),    vecs[i].row);
         checkOutput($sformatf("vec%0d win_col", i),    int'(bus.win_col),    vecs[i].col);
         checkOutput($sformatf("vec%0d conv_valid", i), int'(bus.conv_valid), vecs[i].cv);
         checkOutput($sformatf("vec%0d busy", i),       int'(bus.busy),       vecs[i].busy);
         checkOutput($sformatf("vec%0d done", i),       int'(bus.done),       vecs[i].done);
         checkOutput($sformatf("vec%0d pool_err", i),   int'(bus.pool_err),   vecs[i].err);
         checkOutput($sformatf("vec%0d pool_cnt", i),   int'(bus.pool_cnt),   vecs[i].cnt);
      end

      // full frame: hold 10 cycles at (5,13), stray starts at cycles 100/500, pool model 1 block per 4 convs
      $display("[TB] full frame with hold and stray starts");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      hist[0] = 1'b0;
      expRow = 0; expCol = 0; wins = 0; holdsUsed = 0; convSeen = 0;
      doneCnt = 0; doneCyc = -1; firstWin = -1; lastWin = -1; lastRow = -1; lastCol = -1;
      poolPend = 1'b0;
      for (int c = 1; c < 3000 && !(doneCyc >= 0 && c > doneCyc + 2); c++) begin
         h = (wins < 784) && (expRow == 5) && (expCol == 13) && (holdsUsed < 10);
         if (h) holdsUsed++;
         s = (c == 100) || (c == 500);
         applyStimulus(s, 1'b0, h, poolPend);
         poolPend = 1'b0;
         ew = (wins < 784) && !h;
         hist[c] = ew;
         checkOutput($sformatf("frame c%0d win_valid", c), int'(bus.win_valid), int'(ew));
         if (ew) begin
            checkOutput($sformatf("frame c%0d win_row", c), int'(bus.win_row), expRow);
            checkOutput($sformatf("frame c%0d win_col", c), int'(bus.win_col), expCol);
            if (firstWin < 0) firstWin = c;
            lastWin = c;
            lastRow = int'(bus.win_row);
            lastCol = int'(bus.win_col);
            wins++;
            if (expCol == 27) begin
               expCol = 0;
               expRow++;
            end else begin
               expCol++;
            end
         end
         checkOutput($sformatf("frame c%0d conv_valid", c), int'(bus.conv_valid),
                     (c >= 3) ? int'(hist[c-3]) : 0);
         if (bus.conv_valid) begin
            convSeen++;
            if (convSeen % 4 == 0) poolPend = 1'b1;
         end
         if (bus.done) begin
            doneCnt++;
            if (doneCyc < 0) doneCyc = c;
            checkOutput("frame pool_cnt at done", int'(bus.pool_cnt), 196);
            checkOutput("frame pool_err retained", int'(bus.pool_err), 1);
         end
         if (doneCyc >= 0 && c == doneCyc + 1) begin
            checkOutput("frame busy after done", int'(bus.busy), 0);
         end
      end
      checkOutput("frame done seen in budget", int'(doneCyc >= 0), 1);
      checkOutput("frame done cycle", doneCyc, 800);
      checkOutput("frame done count", doneCnt, 1);
      checkOutput("frame windows", wins, 784);
      checkOutput("frame first window cycle", firstWin, 1);
      checkOutput("frame issue span", lastWin - firstWin + 1, 794);
      checkOutput("frame last row", lastRow, 27);
      checkOutput("frame last col", lastCol, 27);
      checkOutput("frame conv count", convSeen, 784);

      // abort at window (12,0)
      $display("[TB] abort at (12,0)");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      foundCyc = -1;
      for (int c = 1; c <= 400 && foundCyc < 0; c++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         if (bus.win_valid && int'(bus.win_row) == 12 && int'(bus.win_col) == 0) foundCyc = c;
      end
      checkOutput("abort (12,0) cycle", foundCyc, 337);
      bus.abort = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("abort win_valid", int'(bus.win_valid), 0);
      checkOutput("abort conv_valid", int'(bus.conv_valid), 0);
      checkOutput("abort busy", int'(bus.busy), 0);
      checkOutput("abort win_row", int'(bus.win_row), 0);
      checkOutput("abort win_col", int'(bus.win_col), 0);
      checkOutput("abort pool_err kept", int'(bus.pool_err), 1);
      sawDone = int'(bus.done);
      repeat (5) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         if (bus.done || bus.conv_valid) sawDone = 1;
      end
      checkOutput("abort no done/conv afterwards", sawDone, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("restart win_valid", int'(bus.win_valid), 1);
      checkOutput("restart win_row", int'(bus.win_row), 0);
      checkOutput("restart win_col", int'(bus.win_col), 0);

      // run restarted frame into WAIT_POOL, then async reset
      $display("[TB] async reset in WAIT_POOL");
      sawDone = 0;
      for (int c = 2; c <= 801; c++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, (c <= 5) ? 1'b1 : 1'b0);
         if (bus.done) sawDone = 1;
      end
      checkOutput("wait_pool busy", int'(bus.busy), 1);
      checkOutput("wait_pool win_valid", int'(bus.win_valid), 0);
      checkOutput("wait_pool pool_cnt", int'(bus.pool_cnt), 5);
      checkOutput("wait_pool no done", sawDone, 0);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("reset busy", int'(bus.busy), 0);
      checkOutput("reset pool_cnt", int'(bus.pool_cnt), 0);
      checkOutput("reset pool_err", int'(bus.pool_err), 0);
      checkOutput("reset done", int'(bus.done), 0);
      checkOutput("reset conv_valid", int'(bus.conv_valid), 0);
      checkOutput("reset win_valid", int'(bus.win_valid), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("post-reset busy", int'(bus.busy), 0);
      checkOutput("post-reset pool_err", int'(bus.pool_err), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("post-reset first win_valid", int'(bus.win_valid), 1);
      checkOutput("post-reset first win_col", int'(bus.win_col), 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("post-reset second win_col", int'(bus.win_col), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/c1_layer_sequencer.md
Name: c1_layer_sequencer

Overview:
Frame-level controller for the LeNet C1 stage.
- On start, scans 5x5 window positions over the 32x32 input and drives the C1 PEs.
- Generates the aligned conv_valid strobe that feeds the ping-pong pooling register controller.
- Counts returned 2x2 pool blocks and signals frame completion.
- Sits between the top-level frame control and the C1 PE array / register controller.

Parameters:
- IMG_W, 32, input image width and height in pixels.
- K, 5, convolution kernel size; output width OUT_W = IMG_W-K+1 = 28 (localparam).
- PE_LAT, 3, cycles from win_valid to PE result valid; legal range 1..8.
- POOL_BLKS, 196, 2x2 pool blocks expected per frame ((OUT_W/2)^2).

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, frame start request; sampled only in IDLE.
- abort, input, 1, synchronous abort; returns to IDLE from any state.
- hold, input, 1, pauses window issue while high.
- win_valid, output, 1, window coordinates valid this cycle.
- win_row, output, 5, output row (window top-left), 0..OUT_W-1.
- win_col, output, 5, output column (window top-left), 0..OUT_W-1.
- conv_valid, output, 1, win_valid delayed by PE_LAT; drives the register controller.
- pool_valid, input, 1, 2x2 block strobe from the register controller.
- pool_cnt, output, 8, pool blocks received this frame.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse at frame completion.
- pool_err, output, 1, sticky protocol error flag.

Behaviour:
- Reset (async, reset_n low): state=IDLE; all outputs 0; row/col counters 0; conv_valid pipe cleared; pool_err cleared.
- States: IDLE, ISSUE, DRAIN, WAIT_POOL, DONE.
- IDLE:
  - start=1 -> ISSUE next cycle.
  - pool_cnt cleared on the transition.
- ISSUE, per cycle with hold=0:
  - win_valid=1 with current (row,col).
  - col increments; at col=OUT_W-1, col wraps to 0 and row increments.
- ISSUE, per cycle with hold=1:
  - win_valid=0; counters frozen.
  - The conv_valid pipe keeps shifting, so gaps propagate.
- Last window: issued at (27,27) -> DRAIN next cycle; counters reset to 0.
- DRAIN:
  - Wait exactly PE_LAT cycles so the final conv_valid exits the pipe.
  - hold is ignored.
  - -> WAIT_POOL.
- WAIT_POOL: when pool_cnt reaches POOL_BLKS -> DONE.
- DONE: done=1 for one cycle -> IDLE; busy drops in that same IDLE cycle.
- Latency:
  - First win_valid one cycle after start is sampled.
  - conv_valid exactly PE_LAT cycles after each win_valid.
  - With no hold, 784 issue cycles per frame.
- pool_cnt:
  - Increments on pool_valid while busy, including in ISSUE (row-pair blocks return mid-frame).
  - Saturates at POOL_BLKS.
- pool_err: sets (sticky until reset) on either condition:
  - pool_valid while IDLE.
  - pool_valid while pool_cnt==POOL_BLKS.
- start while busy: ignored, no error.
- abort:
  - Highest priority, overriding start and hold.
  - Next cycle: IDLE, counters 0, conv_valid pipe flushed to 0, no done pulse.
  - pool_err is retained.
- start and abort together in IDLE: abort wins and the sequencer stays in IDLE.
- Reset mid-frame: identical to power-on reset.

Optional Feature:
- Macro: C1_SEQ_PERF_EN.
- Defined:
  - Adds output port frame_cycles (16 bits).
  - Counts clk cycles from the ISSUE entry to the DONE state, inclusive.
  - Holds the value until the next start; cleared on reset.
  - Adds output port hold_cycles (16 bits): cycles with hold=1 during ISSUE.
  - Both counters saturate at 16'hFFFF.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package c1_pkg:
  - State encoding localparams (IDLE=0 .. DONE=4, 3 bits).
  - IMG_W, K, OUT_W, POOL_BLKS constants shared with the register controller and the PEs.
- One sub-module: c1_valid_delay.
  - Parameterised PE_LAT-deep shift register with synchronous flush (abort).
  - Produces conv_valid.

Test Plan:
- Basic frame: reset, start=1 for one cycle, hold=0; model register controller attached.
  - win_valid high for 784 consecutive cycles, first (0,0), last (27,27).
  - conv_valid trails by 3 cycles.
  - pool_cnt reaches 196; done pulses once; busy=0 the next cycle.
- Hold mid-row: hold=1 for 10 cycles at (5,13).
  - win_valid=0 for those 10 cycles; resumes at (5,13).
  - conv_valid shows a 10-cycle gap; total issue span 794 cycles.
- Abort during ISSUE at (12,0): abort=1 for one cycle.
  - Next cycle IDLE, win_valid=0, conv_valid=0 within 1 cycle, no done.
  - A following start begins again at (0,0).
- Pool protocol error: pulse pool_valid while IDLE.
  - pool_err=1 and stays 1 across a subsequent full frame, which still completes with done.
- Start while busy: start pulses at cycles 100 and 500 of a frame.
  - No restart; coordinates continue monotonically; exactly one done.
- Async reset mid-WAIT_POOL: reset_n low for 2 cycles.
  - All outputs 0 immediately; pool_cnt=0, pool_err=0; state IDLE after release.
